// File: rtl/cmp_pkg.sv
// Shared types for the comparison stream tracker.
// The tracker state encodings are exposed on a 2-bit port, so the enum is
// built from fixed encodings rather than left to the tool.
package cmp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_SAT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    COUNT = ST_COUNT,
    SAT   = ST_SAT
  } state_t;

endpackage

// File: rtl/cmp_core.sv
// Unsigned magnitude comparator producing one-hot equal/greater/less flags.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   e    : a == b
//   g    : a >  b
//   l    : a <  b
module cmp_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             e,
  output logic             g,
  output logic             l
);

  always_comb begin
    e = (a == b);
    g = (a > b);
    l = (a < b);
  end

endmodule

// File: rtl/cmp_stream_tracker.sv
// Registered, valid/ready comparison stage with statistics on consumed results.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake; in_a, in_b are the operands
//   out_valid/out_ready   : result handshake; out_e/out_g/out_l one-hot flags
//   clr                   : synchronous clear of statistics only
//   cnt_e/cnt_g/cnt_l     : saturating counts of consumed e/g/l results
//   alarm                 : sticky, STREAK consecutive consumed g results
//   state                 : 0 IDLE, 1 COUNT, 2 SAT
module cmp_stream_tracker
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned STREAK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_e,
  output logic             out_g,
  output logic             out_l,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_e,
  output logic [CNT_W-1:0] cnt_g,
  output logic [CNT_W-1:0] cnt_l,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] STREAK_V = CNT_W'(STREAK);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             valid_q;
  logic             e_q, g_q, l_q;
  logic             core_e, core_g, core_l;
  logic             in_xfer, out_xfer, count_en;

  logic [CNT_W-1:0] cnt_e_q, cnt_g_q, cnt_l_q, streak_q;
  logic [CNT_W-1:0] cnt_e_nxt, cnt_g_nxt, cnt_l_nxt, streak_nxt;
  logic             alarm_q, alarm_nxt;
  state_t           state_q, state_nxt;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a (in_a),
    .b (in_b),
    .e (core_e),
    .g (core_g),
    .l (core_l)
  );

  // Ready passes through when the held result drains this cycle.
  assign in_ready = !rst && (!valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;
  // clr takes priority over counting a result consumed in the same cycle.
  assign count_en = out_xfer && !clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      e_q     <= core_e;
      g_q     <= core_g;
      l_q     <= core_l;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

  always_comb begin
    cnt_e_nxt  = cnt_e_q;
    cnt_g_nxt  = cnt_g_q;
    cnt_l_nxt  = cnt_l_q;
    streak_nxt = streak_q;
    alarm_nxt  = alarm_q;
    state_nxt  = state_q;
    if (clr) begin
      cnt_e_nxt  = '0;
      cnt_g_nxt  = '0;
      cnt_l_nxt  = '0;
      streak_nxt = '0;
      alarm_nxt  = 1'b0;
      state_nxt  = IDLE;
    end else if (count_en) begin
      if (e_q && cnt_e_q != CNT_MAX) cnt_e_nxt = cnt_e_q + ONE;
      if (g_q && cnt_g_q != CNT_MAX) cnt_g_nxt = cnt_g_q + ONE;
      if (l_q && cnt_l_q != CNT_MAX) cnt_l_nxt = cnt_l_q + ONE;

      if (g_q) begin
        if (streak_q != CNT_MAX) streak_nxt = streak_q + ONE;
      end else begin
        streak_nxt = '0;
      end
      if (streak_nxt == STREAK_V) alarm_nxt = 1'b1;

      // Saturation is judged on the post-update counts so a single update
      // can move straight into SAT.
      if (cnt_e_nxt == CNT_MAX || cnt_g_nxt == CNT_MAX || cnt_l_nxt == CNT_MAX)
        state_nxt = SAT;
      else if (state_q == IDLE)
        state_nxt = COUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_e_q  <= '0;
      cnt_g_q  <= '0;
      cnt_l_q  <= '0;
      streak_q <= '0;
      alarm_q  <= 1'b0;
      state_q  <= IDLE;
    end else begin
      cnt_e_q  <= cnt_e_nxt;
      cnt_g_q  <= cnt_g_nxt;
      cnt_l_q  <= cnt_l_nxt;
      streak_q <= streak_nxt;
      alarm_q  <= alarm_nxt;
      state_q  <= state_nxt;
    end
  end

  assign out_valid = valid_q;
  assign out_e     = e_q;
  assign out_g     = g_q;
  assign out_l     = l_q;
  assign cnt_e     = cnt_e_q;
  assign cnt_g     = cnt_g_q;
  assign cnt_l     = cnt_l_q;
  assign alarm     = alarm_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Bench for cmp_stream_tracker: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_cmp_stream_tracker;

  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int SK   = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam int AMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, clr;
  logic [W-1:0]  in_a, in_b;
  logic          out_e, out_g, out_l, alarm;
  logic [CW-1:0] cnt_e, cnt_g, cnt_l;
  logic [1:0]    state;

  always #5 clk = ~clk;

  cmp_stream_tracker #(.WIDTH(W), .CNT_W(CW), .STREAK(SK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_e     (out_e),
    .out_g     (out_g),
    .out_l     (out_l),
    .clr       (clr),
    .cnt_e     (cnt_e),
    .cnt_g     (cnt_g),
    .cnt_l     (cnt_l),
    .alarm     (alarm),
    .state     (state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a held result class (-1 none, 0 e, 1 g, 2 l), plain
  // integer counts and a run length of consecutive consumed g results.
  bit m_v;
  int m_cls;
  int m_cnt[3];
  int m_streak;
  bit m_alarm;

  function automatic int cls_of(input int a, input int b);
    if (a == b) return 0;
    if (a > b)  return 1;
    return 2;
  endfunction

  // IDLE while nothing counted, SAT once any count hit its ceiling.
  function automatic int m_state();
    if (m_cnt[0] == CMAX || m_cnt[1] == CMAX || m_cnt[2] == CMAX) return 2;
    if (m_cnt[0] + m_cnt[1] + m_cnt[2] > 0) return 1;
    return 0;
  endfunction

  task automatic cycle();
    bit ir, inx, outx;
    @(negedge clk);
    check("out_valid", out_valid, m_v);
    check("out_e", out_e, m_cls == 0);
    check("out_g", out_g, m_cls == 1);
    check("out_l", out_l, m_cls == 2);
    check("in_ready", in_ready, !rst && (!m_v || out_ready));
    check("cnt_e", cnt_e, m_cnt[0]);
    check("cnt_g", cnt_g, m_cnt[1]);
    check("cnt_l", cnt_l, m_cnt[2]);
    check("alarm", alarm, m_alarm);
    check("state", state, m_state());
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_cls = -1; m_cnt = '{0, 0, 0}; m_streak = 0; m_alarm = 0;
    end else begin
      ir   = !m_v || out_ready;
      inx  = in_valid && ir;
      outx = m_v && out_ready;
      if (clr) begin
        m_cnt = '{0, 0, 0}; m_streak = 0; m_alarm = 0;
      end else if (outx) begin
        if (m_cnt[m_cls] < CMAX) m_cnt[m_cls]++;
        if (m_cls == 1) begin
          if (m_streak < CMAX) m_streak++;
        end else begin
          m_streak = 0;
        end
        if (m_streak == SK) m_alarm = 1;
      end
      if (inx) begin
        m_v = 1; m_cls = cls_of(int'(in_a), int'(in_b));
      end else if (outx) begin
        m_v = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit ordy,
                       input bit c, input bit r);
    in_valid  = v;
    in_a      = W'(a);
    in_b      = W'(b);
    out_ready = ordy;
    clr       = c;
    rst       = r;
    cycle();
  endtask

  initial begin
    m_v = 0; m_cls = -1; m_cnt = '{0, 0, 0}; m_streak = 0; m_alarm = 0;
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("rst_valid", out_valid, 0);
    check("rst_state", state, 0);

    // Single greater pair.
    drive(1, 9, 5, 1, 0, 0);
    check("t1_g", out_g, 1);
    drive(0, 0, 0, 1, 0, 0);
    check("t1_cnt_g", cnt_g, 1);
    check("t1_state", state, 1);

    // Backpressure on an equal result.
    drive(1, 3, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 7, 2, 0, 0, 0);
      check("bp_e_held", out_e, 1);
    end
    drive(1, 7, 2, 1, 0, 0);
    check("bp_cnt_e", cnt_e, 1);
    check("bp_next_g", out_g, 1);
    drive(0, 0, 0, 1, 0, 0);

    // Streak g,g,l,g,g,g then e.
    drive(0, 0, 0, 1, 1, 0);
    drive(1, 5, 1, 1, 0, 0);
    drive(1, 6, 2, 1, 0, 0);
    drive(1, 1, 5, 1, 0, 0);
    check("stk_after_gg", alarm, 0);
    drive(1, 9, 0, 1, 0, 0);
    check("stk_after_l", alarm, 0);
    drive(1, 8, 3, 1, 0, 0);
    drive(1, 4, 2, 1, 0, 0);
    check("stk_before_6th", alarm, 0);
    drive(1, 4, 4, 1, 0, 0);
    check("stk_on_6th", alarm, 1);
    drive(0, 0, 0, 1, 0, 0);
    check("stk_e_keeps", alarm, 1);

    // Saturation of cnt_l.
    drive(0, 0, 0, 1, 1, 0);
    drive(1, 1, 9, 1, 0, 0);
    drive(1, 2, 9, 1, 0, 0);
    check("sat_l1", cnt_l, 1);
    drive(1, 3, 9, 1, 0, 0);
    check("sat_l2", cnt_l, 2);
    drive(1, 4, 9, 1, 0, 0);
    check("sat_l3", cnt_l, 3);
    check("sat_state", state, 2);
    drive(0, 0, 0, 1, 0, 0);
    check("sat_l3_hold", cnt_l, 3);

    // clr coincident with an output transfer.
    drive(0, 0, 0, 1, 1, 0);
    drive(1, 0, AMAX, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    check("clr_cnt_l", cnt_l, 0);
    check("clr_state", state, 0);
    check("clr_valid", out_valid, 0);

    // Boundary operands back to back, then reset mid-stream.
    drive(1, 0, 0, 1, 0, 0);
    check("bnd_e", out_e, 1);
    drive(1, AMAX, 0, 1, 0, 0);
    check("bnd_g", out_g, 1);
    drive(1, 0, AMAX, 1, 0, 0);
    check("bnd_l", out_l, 1);
    check("bnd_valid", out_valid, 1);
    drive(1, 5, 5, 1, 0, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt_e", cnt_e, 0);
    check("mid_rst_cnt_g", cnt_g, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int a, b;
      a = ($urandom_range(0, 3) == 0) ? 0 : (($urandom_range(0, 3) == 0) ? AMAX : int'($urandom_range(0, AMAX)));
      b = ($urandom_range(0, 3) == 0) ? 0 : (($urandom_range(0, 3) == 0) ? AMAX : int'($urandom_range(0, AMAX)));
      drive(bit'($urandom_range(0, 3) != 0), a, b, bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 24) == 0), bit'($urandom_range(0, 199) == 0));
    end
    drive(0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_stream_tracker.md
Name: cmp_stream_tracker

Overview:
Registered, handshaked comparison stage that accepts a stream of unsigned operand pairs (a,b). It produces one-hot equal/greater/less flags per pair and keeps running statistics on the results consumed downstream. It sits between an operand source (valid/ready) and a result consumer. It adds per-class saturating counters and a "consecutive a>b" streak alarm.

Parameters:
WIDTH, 4, operand width in bits (unsigned).
CNT_W, 8, width of each event counter.
STREAK, 3, number of consecutive consumed a>b results that raises the alarm (range 1..2**CNT_W-1).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  stage can accept a pair.
in_a  input  WIDTH  operand a.
in_b  input  WIDTH  operand b.
out_valid  output  1  result flags valid.
out_ready  input  1  consumer accepts result.
out_e  output  1  a==b for the held result.
out_g  output  1  a>b for the held result.
out_l  output  1  a<b for the held result.
clr  input  1  synchronous clear of statistics only.
cnt_e  output  CNT_W  consumed equal results, saturating.
cnt_g  output  CNT_W  consumed greater results, saturating.
cnt_l  output  CNT_W  consumed less results, saturating.
alarm  output  1  sticky: STREAK consecutive a>b results consumed.
state  output  2  tracker state encoding (see below).

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_e/g/l=0, all cnt_*=0, streak=0, alarm=0, state=IDLE. in_ready=0 while rst is high.
- in_ready = !out_valid || out_ready (combinational, so it passes through when the output drains). No skid buffer.
- Input transfer: in_valid && in_ready at an edge. Flags are loaded from the unsigned compare of in_a/in_b, and out_valid becomes 1. Latency is 1 cycle.
- Output transfer: out_valid && out_ready at an edge.
- If there is an output transfer and no input transfer, out_valid becomes 0. Simultaneous input and output transfer sustains one result per cycle.
- Flags are exactly one-hot while out_valid=1. They hold their last value while out_valid=0 (all 0 after reset).
- in_a/in_b are ignored when no transfer occurs. Flags and out_valid are stable while out_valid && !out_ready.
- Statistics update only on an output transfer, using the flags being consumed:
  - The matching cnt_* increments, saturating at 2**CNT_W-1.
  - streak increments on g (saturating) and resets to 0 on e or l.
  - alarm sets when the post-update streak equals STREAK. It stays set until clr or rst.
- clr=1: cnt_*, streak and alarm go to 0 and state goes to IDLE. out_valid and the flags are unaffected. If clr coincides with an output transfer, clr wins and that result is not counted; the pipeline handshake still completes.
- State machine (state: 0=IDLE, 1=COUNT, 2=SAT, 3 unused):
  - IDLE -> COUNT on the first counted output transfer.
  - COUNT -> SAT when any counter reaches all-ones, including on the same update.
  - SAT holds until clr/rst. Counting continues in SAT, with saturation per counter.
  - clr -> IDLE from any state.
- Compare width rule: operands are zero-extended unsigned WIDTH bits. Boundary cases: 0 vs 0 -> e; all-ones vs 0 -> g; 0 vs all-ones -> l.
- rst mid-stream: any held result is dropped (out_valid=0) and is not counted.

Decomposition:
- Package cmp_pkg: a state enum type (IDLE, COUNT, SAT) and localparam encodings for the state values.
- One sub-module: cmp_core, purely combinational. Inputs are a,b [WIDTH]; outputs are e,g,l, one-hot. It is parameterised on WIDTH.
- Handshake register, counters, streak and FSM live in cmp_stream_tracker.

Test Plan:
- Reset then single pair a=9,b=5, out_ready=1 -> next cycle out_valid=1, g=1, e=0, l=0; cycle after, cnt_g=1, state=COUNT.
- Backpressure: send a=3,b=3 with out_ready=0 for 4 cycles -> in_ready=0, flags e=1 held stable. Then out_ready=1 -> one consumption, cnt_e=1, next pair accepted the same cycle.
- Streak: consume g,g,l,g,g,g (STREAK=3) -> alarm is 0 after the first two g, stays 0 after l, and sets exactly on the 6th consumption. A later e does not clear alarm.
- Saturation (CNT_W=2): consume 4 pairs with a<b -> cnt_l sequence 1,2,3,3, state=SAT when cnt_l reaches 3.
- clr coincident with an output transfer of a=0,b=15 -> cnt_l unchanged at 0, state=IDLE, out_valid drops to 0 (no new input).
- Boundaries and throughput: back-to-back (0,0), (15,0), (0,15) with in_valid=out_ready=1 -> results e, g, l on consecutive cycles, no bubbles. Assert rst mid-stream -> out_valid=0 and counts are 0 the next cycle.
